// File: rtl/req2apb_bridge.sv
// Bridges a single-outstanding core request/grant interface onto an APB master port.
// state  | meaning
// IDLE   | waiting for req_i; gnt_o follows req_i and the request is captured on grant
// SETUP  | psel_o high, penable_o low, one cycle
// ACCESS | psel_o and penable_o high until pready_i or timeout
// RESP   | bus released, one-cycle rvalid_o with registered rdata_o/err_o
module req2apb_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic [3:0]                pstrb_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = (CLOG > 8) ? CLOG : 8;
  localparam logic [APB_ADDR_WIDTH-1:0] WORD_MASK = {{(APB_ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          timeout_hit;

  // cnt_q holds the number of ACCESS cycles already spent waiting, so the
  // abort fires in the TIMEOUT_CYCLES-th ACCESS cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    gnt_o   = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) state_d = SETUP;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: if (pready_i || timeout_hit) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pstrb_o   <= 4'h0;
      pwrite_o  <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_o    <= (state_d == SETUP) || (state_d == ACCESS);
      penable_o <= (state_d == ACCESS);
      rvalid_o  <= (state_d == RESP);

      if (state_q == IDLE && req_i) begin
        paddr_o  <= addr_i & WORD_MASK;
        pwrite_o <= we_i;
        pwdata_o <= we_i ? wdata_i : '0;
        pstrb_o  <= we_i ? be_i : 4'h0;
      end

      if (state_q == ACCESS && state_d == ACCESS)
        cnt_q <= (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
      else
        cnt_q <= '0;

      // Normal completion wins over a timeout landing in the same cycle.
      if (state_q == ACCESS && pready_i) begin
        rdata_o <= pwrite_o ? '0 : prdata_i;
        err_o   <= pslverr_i;
      end else if (state_q == ACCESS && timeout_hit) begin
        rdata_o <= '0;
        err_o   <= 1'b1;
      end else begin
        rdata_o <= '0;
        err_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_req2apb_bridge.sv
// Scoreboard bench for req2apb_bridge: a driver issues requests and plays the APB slave,
// a negedge monitor checks bus signals and responses against a queue-based reference model.
module tb_req2apb_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req, we, gnt, rvalid, err, pwrite, psel, penable, pready, pslverr;
  logic [31:0] addr, wdata, rdata, paddr, pwdata, prdata;
  logic [3:0]  be, pstrb;

  req2apb_bridge #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb), .pwrite_o(pwrite),
    .psel_o(psel), .penable_o(penable), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwrite;
    int          setup_cyc;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          rsp_cyc;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: APB access length is the wait count plus one, capped by the timeout.
  function automatic rsp_t model(logic w_e, logic [31:0] pd, logic se, int w, int gcyc);
    rsp_t r;
    bit   timed_out;
    timed_out = (w >= TO);
    r.acc     = timed_out ? TO : w + 1;
    r.rdata   = (timed_out || w_e) ? 32'h0 : pd;
    r.err     = timed_out ? 1'b1 : se;
    r.rsp_cyc = gcyc + 2 + r.acc;
    return r;
  endfunction

  function automatic req_t bus_of(logic [31:0] a, logic w_e, logic [3:0] b, logic [31:0] wd, int gcyc);
    req_t q;
    q.paddr     = {a[31:2], 2'b00};
    q.pwrite    = w_e;
    q.pwdata    = w_e ? wd : 32'h0;
    q.pstrb     = w_e ? b : 4'h0;
    q.setup_cyc = gcyc + 1;
    return q;
  endfunction

  req_t cur;
  int   acc_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      cur     = '{paddr: 32'h0, pwdata: 32'h0, pstrb: 4'h0, pwrite: 1'b0, setup_cyc: 0};
      acc_cnt = 0;
    end else begin
      if (psel && !penable) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_setup actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          cur = exp_req.pop_front();
          chk("setup_cycle", cyc, cur.setup_cyc);
        end
      end
      chk("paddr", paddr, cur.paddr);
      chk("pwdata", pwdata, cur.pwdata);
      chk("pstrb", {28'h0, pstrb}, {28'h0, cur.pstrb});
      chk("pwrite", {31'h0, pwrite}, {31'h0, cur.pwrite});
      if (penable) begin
        acc_cnt++;
        chk("psel_in_access", {31'h0, psel}, 32'h1);
      end
      if (rvalid) begin
        chk("resp_bus_idle", {30'h0, psel, penable}, 32'h0);
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("err", {31'h0, err}, {31'h0, e.err});
          chk("access_cycles", acc_cnt, e.acc);
          chk("rvalid_cycle", cyc, e.rsp_cyc);
        end
        acc_cnt = 0;
      end else begin
        chk("rdata_outside_resp", rdata, 32'h0);
        chk("err_outside_resp", {31'h0, err}, 32'h0);
      end
    end
  end

  task automatic scramble();
    req   = 1'($urandom_range(0, 1));
    addr  = $urandom;
    we    = 1'($urandom_range(0, 1));
    be    = 4'($urandom);
    wdata = $urandom;
  endtask

  task automatic do_txn(logic [31:0] a, logic w_e, logic [3:0] b, logic [31:0] wd,
                        int w, logic [31:0] pd, logic se);
    int gcyc;
    int acc;
    @(negedge clk);
    req = 1'b1; addr = a; we = w_e; be = b; wdata = wd; pready = 1'b0;
    #1 chk("gnt_idle", {31'h0, gnt}, 32'h1);
    gcyc = cyc;
    exp_req.push_back(bus_of(a, w_e, b, wd, gcyc));
    exp_rsp.push_back(model(w_e, pd, se, w, gcyc));
    acc = (w < TO) ? w + 1 : TO;
    @(negedge clk);
    scramble();
    pready = 1'($urandom_range(0, 1)); prdata = $urandom;
    #1 chk("gnt_busy", {31'h0, gnt}, 32'h0);
    for (int k = 0; k < acc; k++) begin
      @(negedge clk);
      scramble();
      pready  = (k == w);
      prdata  = (k == w) ? pd : $urandom;
      pslverr = (k == w) ? se : 1'($urandom_range(0, 1));
      #1 chk("gnt_busy", {31'h0, gnt}, 32'h0);
    end
    @(negedge clk);
    scramble();
    pready = 1'($urandom_range(0, 1));
    #1 chk("gnt_resp", {31'h0, gnt}, 32'h0);
    req = 1'b0; pready = 1'b0;
  endtask

  task automatic back_to_back();
    int          n0;
    int          g[$];
    logic [31:0] pd;
    pd = 32'h600D_D00D;
    @(negedge clk);
    req = 1'b1; addr = 32'h4000_0010; we = 1'b0; be = 4'hF; wdata = 32'h0;
    pready = 1'b1; prdata = pd; pslverr = 1'b0;
    n0 = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(bus_of(addr, 1'b0, be, 32'h0, n0 + 4 * i));
      exp_rsp.push_back(model(1'b0, pd, 1'b0, 0, n0 + 4 * i));
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 9) req = 1'b0;
      #1 if (gnt) g.push_back(cyc);
      @(negedge clk);
    end
    pready = 1'b0;
    chk("b2b_gnt_count", g.size(), 3);
    for (int i = 0; i < g.size() && i < 3; i++) chk("b2b_gnt_cycle", g[i], n0 + 4 * i);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    req = 1'b1; addr = 32'h3000_0008; we = 1'b1; be = 4'h3; wdata = 32'hA5A5_5A5A;
    pready = 1'b0;
    #1 chk("gnt_idle", {31'h0, gnt}, 32'h1);
    exp_req.push_back(bus_of(addr, 1'b1, be, wdata, cyc));
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 chk("rst_psel", {31'h0, psel}, 32'h0);
    chk("rst_penable", {31'h0, penable}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_psel", {31'h0, psel}, 32'h0);
    chk("reset_penable", {31'h0, penable}, 32'h0);
    chk("reset_rvalid", {31'h0, rvalid}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_paddr", paddr, 32'h0);
    chk("reset_pwdata", pwdata, 32'h0);
    chk("reset_pstrb", {28'h0, pstrb}, 32'h0);
    chk("reset_pwrite", {31'h0, pwrite}, 32'h0);
    chk("reset_gnt", {31'h0, gnt}, 32'h0);
    #1 rst = 1'b0;

    do_txn(32'h1A10_0004, 1'b0, 4'hF, 32'h5555_AAAA, 0, 32'hDEAD_BEEF, 1'b0);
    do_txn(32'h1A10_1003, 1'b1, 4'h8, 32'h1234_5678, 3, 32'hCAFE_F00D, 1'b0);
    do_txn(32'h0000_0102, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_F00D, 1'b1);
    do_txn(32'h0000_0200, 1'b0, 4'hF, 32'h0, 9, 32'h1111_2222, 1'b0);
    do_txn(32'h0000_0300, 1'b1, 4'h5, 32'h7777_8888, TO, 32'h3333_4444, 1'b0);
    back_to_back();
    reset_mid();
    do_txn(32'h1A10_0004, 1'b0, 4'hF, 32'h0, 0, 32'h8765_4321, 1'b0);

    for (int i = 0; i < 25; i++)
      do_txn($urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
             $urandom_range(0, 7), $urandom, 1'($urandom_range(0, 1)));

    repeat (5) @(negedge clk);
    chk("leftover_requests", exp_req.size(), 0);
    chk("leftover_responses", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
